// File: rtl/udp_pkg.sv
// Shared constants and FSM state type for the UDP transmit buffer.
package udp_pkg;

    localparam logic [31:0] FRAME_HEAD_DEF = 32'hF3ED7A93;
    localparam int          HEAD_LEN       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/udp_tx_fifo.sv
// Byte FIFO with a two-byte write port (high byte first), single-byte first-word-fall-through read.
// The caller guarantees at least 2 free entries on write and at least 1 entry on read.
module udp_tx_fifo #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [15:0]              wdata,
    input  logic                     rd,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(2);
            if (rd) rptr <= rptr + AW'(1);
            count <= count + (wr ? (AW+1)'(2) : '0) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr]          <= wdata[15:8];
            mem[wptr + AW'(1)] <= wdata[7:0];
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/udp_tx_buf.sv
// Packs 16-bit pixels into a byte FIFO and emits UDP payload packets via request/ack, prefixing the frame head.
// Define UDP_TX_STAT_EN to add the pkt_cnt / drop_cnt statistics ports.
module udp_tx_buf
    import udp_pkg::*;
#(
    parameter logic [31:0] FRAME_HEAD = FRAME_HEAD_DEF,
    parameter int          PKT_BYTES  = 1024,
    parameter int          FIFO_DEPTH = 4096,
    parameter int          GAP_CYCLES = 16
) (
    input  logic        app_tx_clk,
    input  logic        rstn,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [15:0] vid_data,
    input  logic [24:0] app_tx_data_total,
    output logic        app_tx_data_request,
    input  logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic [15:0] app_tx_data_length,
    output logic        overflow,
`ifdef UDP_TX_STAT_EN
    output logic [31:0] pkt_cnt,
    output logic [15:0] drop_cnt,
`endif
    output tx_state_t   dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state, state_nx;
    logic [CW-1:0] fifo_cnt, stale_cnt;
    logic [7:0]    fifo_rdata, head_byte;
    logic          fifo_wr, fifo_rd, drop, full, in_frame, total_hit;
    logic          vs_q, vs_rise, flush, head_pending, send_head, in_head, launch;
    logic [24:0]   frame_cnt, frame_base;
    logic [15:0]   idx, avail, cand_len;

    udp_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (app_tx_clk),
        .rst_n (rstn),
        .wr    (fifo_wr),
        .wdata (vid_data),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .count (fifo_cnt)
    );

    // A pixel arriving on the vs edge cycle already belongs to the new frame.
    assign vs_rise    = vid_vs & ~vs_q;
    assign frame_base = vs_rise ? '0 : frame_cnt;
    assign in_frame   = frame_base < app_tx_data_total;
    assign full       = fifo_cnt > CW'(FIFO_DEPTH - 2);
    assign fifo_wr    = vid_de && in_frame && !full;
    assign drop       = vid_de && in_frame && full;
    assign total_hit  = fifo_wr && ((26'(frame_base) + 26'd2) >= 26'(app_tx_data_total));

    // Bytes left over from the previous frame (stale_cnt) go out head-less before the new head.
    always_comb begin
        if (stale_cnt != '0)  avail = 16'(stale_cnt);
        else if (head_pending) avail = 16'(fifo_cnt) + 16'(HEAD_LEN);
        else                  avail = 16'(fifo_cnt);
        cand_len = (avail > 16'(PKT_BYTES)) ? 16'(PKT_BYTES) : avail;
        launch   = (cand_len == 16'(PKT_BYTES)) || (stale_cnt != '0) || (flush && fifo_cnt != '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (launch) state_nx = REQ;
            REQ:  if (app_tx_ack) state_nx = SEND;
            SEND: if (idx == app_tx_data_length - 16'd1) state_nx = GAP;
            GAP:  if (idx == 16'(GAP_CYCLES - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        head_byte = 8'h00;
        case (idx[1:0])
            2'd0: head_byte = FRAME_HEAD[31:24];
            2'd1: head_byte = FRAME_HEAD[23:16];
            2'd2: head_byte = FRAME_HEAD[15:8];
            2'd3: head_byte = FRAME_HEAD[7:0];
            default: head_byte = 8'h00;
        endcase
    end

    assign in_head             = send_head && (idx < 16'(HEAD_LEN));
    assign app_tx_data_valid   = (state == SEND);
    assign app_tx_data_request = (state == REQ);
    assign fifo_rd             = app_tx_data_valid && !in_head;
    assign app_tx_data         = app_tx_data_valid ? (in_head ? head_byte : fifo_rdata) : 8'h00;
    assign dbg_state           = state;

    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            idx                <= '0;
            app_tx_data_length <= '0;
            send_head          <= 1'b0;
            vs_q               <= 1'b0;
            frame_cnt          <= '0;
            head_pending       <= 1'b0;
            stale_cnt          <= '0;
            flush              <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            state <= state_nx;
            vs_q  <= vid_vs;
            case (state)
                IDLE: if (launch) begin
                    app_tx_data_length <= cand_len;
                    send_head          <= head_pending && (stale_cnt == '0);
                    idx                <= '0;
                end
                SEND: idx <= (state_nx == GAP) ? 16'd0 : idx + 16'd1;
                GAP: begin
                    idx <= idx + 16'd1;
                    if (state_nx == IDLE) begin
                        idx                <= '0;
                        app_tx_data_length <= '0;
                    end
                end
                default: ;
            endcase

            if (fifo_wr)      frame_cnt <= frame_base + 25'd2;
            else if (vs_rise) frame_cnt <= '0;

            if (vs_rise)                                      head_pending <= 1'b1;
            else if (in_head && idx == 16'(HEAD_LEN - 1))     head_pending <= 1'b0;

            if (vs_rise)                          stale_cnt <= fifo_cnt - CW'(fifo_rd);
            else if (fifo_rd && stale_cnt != '0)  stale_cnt <= stale_cnt - CW'(1);

            if (total_hit)                      flush <= 1'b1;
            else if (vs_rise || fifo_cnt == '0) flush <= 1'b0;

            if (drop)         overflow <= 1'b1;
            else if (vs_rise) overflow <= 1'b0;
        end
    end

`ifdef UDP_TX_STAT_EN
    always_ff @(posedge app_tx_clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == SEND && state_nx == GAP) pkt_cnt <= pkt_cnt + 32'd1;
            if (drop && drop_cnt != 16'hFFFF)     drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_tx_buf.sv
// Directed bench for udp_tx_buf (PKT_BYTES=16, GAP_CYCLES=4, FIFO_DEPTH=64); define UDP_TX_STAT_EN for counters.
module tb_udp_tx_buf;
    import udp_pkg::*;

    localparam int PKT = 16;
    localparam int GAPC = 4;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vid_vs = 1'b0;
    logic        vid_de = 1'b0;
    logic [15:0] vid_data = '0;
    logic [24:0] total = 25'd24;
    logic        req;
    logic        ack = 1'b0;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] len;
    logic        ovf;
    tx_state_t   st;
`ifdef UDP_TX_STAT_EN
    logic [31:0] pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] head_v;

    always #5 clk = ~clk;

    udp_tx_buf #(.PKT_BYTES(PKT), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAPC)) dut (
        .app_tx_clk          (clk),
        .rstn                (rstn),
        .vid_vs              (vid_vs),
        .vid_de              (vid_de),
        .vid_data            (vid_data),
        .app_tx_data_total   (total),
        .app_tx_data_request (req),
        .app_tx_ack          (ack),
        .app_tx_data_valid   (valid),
        .app_tx_data         (data),
        .app_tx_data_length  (len),
        .overflow            (ovf),
`ifdef UDP_TX_STAT_EN
        .pkt_cnt             (pkt_cnt),
        .drop_cnt            (drop_cnt),
`endif
        .dbg_state           (st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: collects every payload byte and per-packet length / byte count.
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          pkt_len_q[$];
    int          pkt_bytes_q[$];
    int          len_jitter = 0;
    logic        prev_valid = 1'b0;
    int          cur_bytes = 0;
    logic [15:0] cur_len = '0;

    initial forever begin
        @(negedge clk);
        if (valid) begin
            if (!prev_valid) begin
                cur_bytes = 0;
                cur_len = len;
                pkt_len_q.push_back(int'(len));
            end else if (len != cur_len) begin
                len_jitter++;
            end
            rx_q.push_back(data);
            cur_bytes++;
        end else if (prev_valid) begin
            pkt_bytes_q.push_back(cur_bytes);
        end
        prev_valid = valid;
    end

    // Ack responder: acks ack_delay cycles after request rises, unless held off.
    int   ack_delay = 3;
    logic ack_en = 1'b1;
    int   ack_wait = 0;

    initial forever begin
        @(negedge clk);
        if (req && ack_en && !ack) begin
            ack_wait++;
            if (ack_wait >= ack_delay) begin
                ack = 1'b1;
                ack_wait = 0;
            end
        end else begin
            ack = 1'b0;
            if (!req) ack_wait = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        vid_de = 1'b0;
        vid_vs = 1'b0;
        ack_en = 1'b1;
        tick(3);
        #1 rstn = 1'b1;
    endtask

    task automatic vs_pulse;
        @(posedge clk);
        #1 vid_vs = 1'b1;
        @(posedge clk);
        #1 vid_vs = 1'b0;
    endtask

    task automatic send_pixels(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 vid_de = 1'b1;
            vid_data = base + 16'(i);
        end
        @(posedge clk);
        #1 vid_de = 1'b0;
    endtask

    task automatic clear_mon;
        rx_q.delete();
        exp_q.delete();
        pkt_len_q.delete();
        pkt_bytes_q.delete();
        len_jitter = 0;
    endtask

    task automatic exp_head;
        for (int i = 0; i < 4; i++) exp_q.push_back(head_v[31-8*i -: 8]);
    endtask

    task automatic exp_pixels(input int n, input logic [15:0] base);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = base + 16'(i);
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
        end
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        int n = 0;
        while (q < 30 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!valid && !req && st == IDLE) q++;
            else q = 0;
        end
        check({tag, " settle"}, 32'(n < 3000), 32'd1);
    endtask

    function automatic int len_at(input int i);
        return (i < pkt_len_q.size()) ? pkt_len_q[i] : -1;
    endfunction

    function automatic int bytes_at(input int i);
        return (i < pkt_bytes_q.size()) ? pkt_bytes_q[i] : -1;
    endfunction

    task automatic compare_stream(input string tag);
        check({tag, " byte count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    task automatic check_two_pkts(input string tag);
        check({tag, " pkt count"}, pkt_len_q.size(), 2);
        check({tag, " len0"}, len_at(0), 16);
        check({tag, " len1"}, len_at(1), 12);
        check({tag, " bytes0"}, bytes_at(0), 16);
        check({tag, " bytes1"}, bytes_at(1), 12);
        check({tag, " len stable"}, len_jitter, 0);
    endtask

    initial begin
        int bad;
        int prev;
        int npix;
        logic [15:0] l0;
        logic [15:0] v;
        head_v = 32'hF3ED7A93;

        // Reset state
        tick(2);
        @(negedge clk);
        check("rst request", req, 0);
        check("rst valid", valid, 0);
        check("rst data", data, 0);
        check("rst length", len, 0);
        check("rst overflow", ovf, 0);
        check("rst state", 32'(st), 32'(IDLE));
        @(posedge clk);
        #1 rstn = 1'b1;

        // 1: head + 12 bytes, then 12-byte tail on total reached
        clear_mon();
        exp_head();
        exp_pixels(12, 16'h1000);
        vs_pulse();
        send_pixels(12, 16'h1000);
        wait_quiet("s1");
        check_two_pkts("s1");
        check("s1 overflow", ovf, 0);
        compare_stream("s1");
`ifdef UDP_TX_STAT_EN
        check("s6 pkt_cnt", pkt_cnt, 2);
        check("s6 drop_cnt", drop_cnt, 0);
`endif

        // 2: vs edge with 6 bytes buffered -> head-less short packet, then head packet
        clear_mon();
        exp_pixels(3, 16'h2000);
        exp_head();
        exp_pixels(6, 16'h2100);
        vs_pulse();
        send_pixels(3, 16'h2000);
        tick(20);
        check("s2 head waits", pkt_len_q.size(), 0);
        vs_pulse();
        send_pixels(6, 16'h2100);
        wait_quiet("s2");
        check("s2 pkt count", pkt_len_q.size(), 2);
        check("s2 len0", len_at(0), 6);
        check("s2 len1", len_at(1), 16);
        check("s2 bytes0", bytes_at(0), 6);
        check("s2 bytes1", bytes_at(1), 16);
        compare_stream("s2");

        // 3: ack held off 50 cycles during a long stream
        do_reset();
        clear_mon();
        total = 25'd20000;
        ack_en = 1'b0;
        vs_pulse();
        fork
            send_pixels(2000, 16'h0000);
            begin
                bad = 0;
                while (!req && bad < 200) begin
                    @(negedge clk);
                    bad++;
                end
                check("s3 request seen", req, 1);
                l0 = len;
                bad = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (!req || len != l0) bad++;
                end
                check("s3 req/len held", bad, 0);
                check("s3 held len", l0, 16);
                ack_en = 1'b1;
            end
        join
        check("s3 overflow", ovf, 1);
        vs_pulse();
        wait_quiet("s3");
        check("s3 len stable", len_jitter, 0);
        bad = 0;
        for (int i = 0; i < pkt_len_q.size(); i++)
            if (bytes_at(i) != pkt_len_q[i]) bad++;
        check("s3 pkt len vs bytes", bad, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("s3 head%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'h00, head_v[31-8*i -: 8]);
        check("s3 even payload", (rx_q.size() - 4) % 2, 0);
        npix = (rx_q.size() - 4) / 2;
        check("s3 drops seen", 32'(npix < 2000), 1);
        check("s3 first pixel", (rx_q.size() > 5) ? {rx_q[4], rx_q[5]} : 16'hFFFF, 0);
        prev = -1;
        bad = 0;
        for (int j = 4; j + 1 < rx_q.size(); j += 2) begin
            v = {rx_q[j], rx_q[j+1]};
            if (int'(v) <= prev) bad++;
            prev = int'(v);
        end
        check("s3 order", bad, 0);

        // 4: reset asserted during the 5th byte of SEND
        do_reset();
        clear_mon();
        total = 25'd24;
        vs_pulse();
        fork
            send_pixels(12, 16'h4000);
            begin
                bad = 0;
                while (!valid && bad < 200) begin
                    @(negedge clk);
                    bad++;
                end
                repeat (4) @(negedge clk);
                check("s4 in send", valid, 1);
                rstn = 1'b0;
                #1;
                check("s4 valid drop", valid, 0);
                check("s4 request drop", req, 0);
                check("s4 length drop", len, 0);
            end
        join
        tick(2);
        #1 rstn = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid || req) bad++;
        end
        check("s4 quiet after reset", bad, 0);
        clear_mon();
        exp_head();
        exp_pixels(12, 16'h4100);
        vs_pulse();
        send_pixels(12, 16'h4100);
        wait_quiet("s4");
        check_two_pkts("s4");
        compare_stream("s4");

        // 5: 30 pixels with total=24 -> only 24 payload bytes
        do_reset();
        clear_mon();
        total = 25'd24;
        exp_head();
        exp_pixels(12, 16'h5000);
        vs_pulse();
        send_pixels(30, 16'h5000);
        wait_quiet("s5");
        check_two_pkts("s5");
        check("s5 overflow", ovf, 0);
        compare_stream("s5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
